jpeg_pingpong_block_ctrl: RTL and testbench

Ping-pong controller for two 64-entry 8-bit pixel block buffers in the JPEG encoder front end. Accepts a raster-ordered 8x8 pixel stream over valid/ready and steers each pixel into the currently filling buffer through its 1-pixel write port. Offers each completed block to the DCT stage with a valid/ready/done handshake, so one buffer can fill while the other is read.

---
 rtl/jpeg_pkg.sv | 22 ++
 rtl/jpeg_pingpong_block_ctrl_if.sv | 26 ++
 rtl/jpeg_buf_slot_fsm.sv | 40 ++++
 rtl/jpeg_pingpong_block_ctrl.sv | 115 +++++++++++
 tb/tb_jpeg_pingpong_block_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG front-end ping-pong block buffer controller.
package jpeg_pkg;

  localparam logic [1:0] BUF_EMPTY   = 2'd0;
  localparam logic [1:0] BUF_FILLING = 2'd1;
  localparam logic [1:0] BUF_FULL    = 2'd2;
  localparam logic [1:0] BUF_BUSY    = 2'd3;

  localparam int BLOCK_PIX = 64;

  typedef enum logic [1:0] {
    ST_EMPTY   = BUF_EMPTY,
    ST_FILLING = BUF_FILLING,
    ST_FULL    = BUF_FULL,
    ST_BUSY    = BUF_BUSY
  } buf_state_e;

  function automatic logic [1:0] buf_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/jpeg_pingpong_block_ctrl_if.sv
// Pixel stream, buffer write port and DCT block handshake bundle.
interface jpeg_pingpong_block_ctrl_if #(parameter int DATA_WIDTH = 8);

  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_ready;
  logic [1:0]            buf_wr_en;
  logic [DATA_WIDTH-1:0] buf_wr_data;
  logic                  blk_valid;
  logic                  blk_sel;
  logic                  blk_ready;
  logic                  blk_done;
  logic [15:0]           blk_count;
  logic                  err_done;

  modport master (
    output pix_valid, pix_data, blk_ready, blk_done,
    input  pix_ready, buf_wr_en, buf_wr_data, blk_valid, blk_sel, blk_count, err_done
  );

  modport slave (
    input  pix_valid, pix_data, blk_ready, blk_done,
    output pix_ready, buf_wr_en, buf_wr_data, blk_valid, blk_sel, blk_count, err_done
  );

endinterface

// File: rtl/jpeg_buf_slot_fsm.sv
// Lifecycle of one block buffer: EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
module jpeg_buf_slot_fsm
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fill_start,
  input  logic       fill_last,
  input  logic       take,
  input  logic       release_buf,
  output buf_state_e state
);

  buf_state_e state_r;
  buf_state_e state_nxt;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // next-state selection
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_EMPTY:   if (fill_start)  state_nxt = ST_FILLING; else state_nxt = ST_EMPTY;
      ST_FILLING: if (fill_last)   state_nxt = ST_FULL;    else state_nxt = ST_FILLING;
      ST_FULL:    if (take)        state_nxt = ST_BUSY;    else state_nxt = ST_FULL;
      ST_BUSY:    if (release_buf) state_nxt = ST_EMPTY;   else state_nxt = ST_BUSY;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  assign state = state_r;

endmodule

// File: rtl/jpeg_pingpong_block_ctrl.sv
// Ping-pong controller: fills one 64-pixel buffer while the DCT reads the other.
module jpeg_pingpong_block_ctrl
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = BLOCK_PIX
) (
  input  logic                      clk,
  input  logic                      rst,
  jpeg_pingpong_block_ctrl_if.slave bus
);

  localparam logic [5:0] CNT_LAST = 6'(DEPTH - 1);

  buf_state_e            slot_state [2];
  logic                  wr_buf_r;
  logic                  rd_buf_r;
  logic [5:0]            fill_cnt_r;
  logic                  last_r;
  logic                  last_buf_r;
  logic [1:0]            wr_en_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [15:0]           blk_count_r;
  logic                  err_r;

  logic       pix_ready_s;
  logic       accept_s;
  logic       any_busy_s;
  logic       busy_idx_s;
  logic       blk_valid_s;
  logic       blk_sel_s;
  logic       take_s;
  logic       release_s;
  logic [1:0] fill_start_s;
  logic [1:0] fill_last_s;
  logic [1:0] take_vec_s;
  logic [1:0] release_vec_s;

  // handshake decode from registered state only
  always_comb begin
    pix_ready_s   = (slot_state[wr_buf_r] == ST_EMPTY) || (slot_state[wr_buf_r] == ST_FILLING);
    accept_s      = bus.pix_valid && pix_ready_s;
    any_busy_s    = (slot_state[0] == ST_BUSY) || (slot_state[1] == ST_BUSY);
    busy_idx_s    = (slot_state[1] == ST_BUSY);
    blk_valid_s   = (slot_state[rd_buf_r] == ST_FULL) && !any_busy_s;
    take_s        = blk_valid_s && bus.blk_ready;
    release_s     = bus.blk_done && any_busy_s;
    fill_start_s  = accept_s ? buf_onehot(wr_buf_r) : 2'b00;
    fill_last_s   = last_r ? buf_onehot(last_buf_r) : 2'b00;
    take_vec_s    = take_s ? buf_onehot(rd_buf_r) : 2'b00;
    release_vec_s = release_s ? buf_onehot(busy_idx_s) : 2'b00;
    if (blk_valid_s) begin
      blk_sel_s = rd_buf_r;
    end else if (any_busy_s) begin
      blk_sel_s = busy_idx_s;
    end else begin
      blk_sel_s = rd_buf_r;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_slot
    jpeg_buf_slot_fsm u_slot (
      .clk         (clk),
      .rst         (rst),
      .fill_start  (fill_start_s[k]),
      .fill_last   (fill_last_s[k]),
      .take        (take_vec_s[k]),
      .release_buf (release_vec_s[k]),
      .state       (slot_state[k])
    );
  end

  // fill pointer, write port, handoff counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_buf_r    <= 1'b0;
      rd_buf_r    <= 1'b0;
      fill_cnt_r  <= 6'd0;
      last_r      <= 1'b0;
      last_buf_r  <= 1'b0;
      wr_en_r     <= 2'b00;
      wr_data_r   <= '0;
      blk_count_r <= 16'd0;
      err_r       <= 1'b0;
    end else begin
      wr_en_r    <= fill_start_s;
      // FULL is marked one edge later, together with the 64th buffer write
      last_r     <= accept_s && (fill_cnt_r == CNT_LAST);
      last_buf_r <= wr_buf_r;
      if (accept_s) begin
        wr_data_r  <= bus.pix_data;
        fill_cnt_r <= fill_cnt_r + 6'd1;
        if (fill_cnt_r == CNT_LAST) begin
          wr_buf_r <= ~wr_buf_r;
        end
      end
      if (take_s) begin
        rd_buf_r    <= ~rd_buf_r;
        blk_count_r <= blk_count_r + 16'd1;
      end
      if (bus.blk_done && !any_busy_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.pix_ready   = pix_ready_s;
  assign bus.buf_wr_en   = wr_en_r;
  assign bus.buf_wr_data = wr_data_r;
  assign bus.blk_valid   = blk_valid_s;
  assign bus.blk_sel     = blk_sel_s;
  assign bus.blk_count   = blk_count_r;
  assign bus.err_done    = err_r;

endmodule

// File: tb/tb_jpeg_pingpong_block_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a block-level model.
module tb_jpeg_pingpong_block_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jpeg_pingpong_block_ctrl_if #(.DATA_WIDTH(8)) bus ();

  jpeg_pingpong_block_ctrl #(.DATA_WIDTH(8), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  // model: which buffer fills, which is offered next, which the DCT owns
  int         m_wr, m_rd, m_own, m_pending, m_blk_count;
  bit         m_full [2];
  bit         m_err;
  logic [7:0] cur_q [$];
  logic [7:0] m_block [2][64];
  logic [1:0] m_wr_en;
  logic [7:0] m_wr_data;

  // behavioural pixel buffers driven by the DUT write port
  logic [7:0] mem [2][64];
  int         widx [2];

  int cyc, stalls, done_due;
  int sel_q [$];
  logic [1:0] seen_wr_en;
  logic [7:0] seen_wr_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return !(m_full[m_wr] || (m_own == m_wr));
  endfunction

  function automatic bit exp_valid();
    return m_full[m_rd] && (m_own < 0);
  endfunction

  function automatic int exp_sel();
    if (exp_valid()) return m_rd;
    if (m_own >= 0) return m_own;
    return m_rd;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_own = -1; m_pending = -1; m_blk_count = 0;
    m_full[0] = 1'b0; m_full[1] = 1'b0; m_err = 1'b0;
    cur_q.delete();
    m_wr_en = 2'b00; m_wr_data = 8'h00;
    widx[0] = 0; widx[1] = 0;
    done_due = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b0; bus.pix_data = 8'h00; bus.blk_ready = 1'b0; bus.blk_done = 1'b0;
    #1;
    check_val("rst_wr_en", bus.buf_wr_en, 2'b00);
    check_val("rst_blk_valid", bus.blk_valid, 1'b0);
    check_val("rst_blk_count", bus.blk_count, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // one clock: check outputs at negedge, drive, advance model across the edge
  task automatic step(input bit pv, input logic [7:0] pd, input bit br, input bit bd, output bit acc);
    bit tk, rl;
    int bad;
    check_val("pix_ready", bus.pix_ready, exp_ready());
    check_val("blk_valid", bus.blk_valid, exp_valid());
    check_val("blk_sel", bus.blk_sel, exp_sel());
    check_val("buf_wr_en", bus.buf_wr_en, m_wr_en);
    check_val("buf_wr_data", bus.buf_wr_data, m_wr_data);
    check_val("blk_count", bus.blk_count, m_blk_count);
    check_val("err_done", bus.err_done, m_err);
    seen_wr_en = bus.buf_wr_en;
    seen_wr_data = bus.buf_wr_data;
    bus.pix_valid = pv; bus.pix_data = pd; bus.blk_ready = br; bus.blk_done = bd;
    acc = pv && exp_ready();
    tk  = exp_valid() && br;
    rl  = bd && (m_own >= 0);
    if (pv && !exp_ready()) stalls++;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (seen_wr_en[k]) begin
        mem[k][widx[k]] = seen_wr_data;
        widx[k] = (widx[k] + 1) % 64;
      end
    end
    if (m_pending >= 0) begin
      m_full[m_pending] = 1'b1;
      m_pending = -1;
    end
    m_wr_en = acc ? ((m_wr == 1) ? 2'b10 : 2'b01) : 2'b00;
    if (acc) begin
      m_wr_data = pd;
      cur_q.push_back(pd);
      if (cur_q.size() == 64) begin
        for (int i = 0; i < 64; i++) m_block[m_wr][i] = cur_q[i];
        cur_q.delete();
        m_pending = m_wr;
        m_wr ^= 1;
      end
    end
    if (bd && !rl) m_err = 1'b1;
    if (rl) m_own = -1;
    if (tk) begin
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem[m_rd][i] !== m_block[m_rd][i]) bad++;
      check_val("blk_data", bad, 0);
      sel_q.push_back(m_rd);
      m_full[m_rd] = 1'b0;
      m_own = m_rd;
      m_rd ^= 1;
      m_blk_count = (m_blk_count + 1) % 65536;
      done_due = cyc + 62;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int bad, sent, guard;
    logic [7:0] newpix [64];
    checks = 0; errors = 0; cyc = 0; stalls = 0;
    model_reset();
    do_reset();

    // raster block 0..63 into buffer 0
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_val("p1_blk_valid", bus.blk_valid, 1'b1);
    check_val("p1_blk_sel", bus.blk_sel, 1'b0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[0][i] !== 8'(i)) bad++;
    check_val("p1_buf0_data", bad, 0);

    // DCT not ready: buffer 1 fills, then the stream stalls
    for (int i = 0; i < 80; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    check_val("p2_pix_ready", bus.pix_ready, 1'b0);
    check_val("p2_no_write", bus.buf_wr_en, 2'b00);

    // hand off buffer 0, release it 10 cycles later
    step(1'b1, 8'h5a, 1'b1, 1'b0, acc);
    for (int i = 0; i < 9; i++) step(1'b1, 8'h5a, 1'b0, 1'b0, acc);
    step(1'b1, 8'h5a, 1'b0, 1'b1, acc);
    check_val("p3_accept_in_release", acc, 1'b0);
    check_val("p3_blk_count", bus.blk_count, 16'd1);
    check_val("p3_blk_valid", bus.blk_valid, 1'b1);
    check_val("p3_blk_sel", bus.blk_sel, 1'b1);
    check_val("p3_pix_ready", bus.pix_ready, 1'b1);

    // sustained stream, 8 blocks, DCT releases 62 cycles after each handoff
    do_reset();
    stalls = 0; sel_q.delete(); sent = 0; guard = 0;
    while (m_blk_count < 8 && guard < 2000) begin
      step(sent < 512, 8'($urandom), 1'b1, cyc == done_due, acc);
      if (acc) sent++;
      guard++;
    end
    check_val("p4_stalls", stalls, 0);
    check_val("p4_blk_count", bus.blk_count, 16'd8);
    bad = 0;
    for (int i = 0; i < sel_q.size(); i++) if (sel_q[i] != (i % 2)) bad++;
    check_val("p4_sel_alternate", bad, 0);

    // spurious done with nothing owned
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_val("p5_err_done", bus.err_done, 1'b1);
    check_val("p5_pix_ready", bus.pix_ready, 1'b1);
    check_val("p5_blk_valid", bus.blk_valid, 1'b0);

    // reset mid-fill discards the partial block
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      newpix[i] = 8'($urandom);
      step(1'b1, newpix[i], 1'b0, 1'b0, acc);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[0][i] !== newpix[i]) bad++;
    check_val("p6_buf0_data", bad, 0);
    check_val("p6_blk_valid", bus.blk_valid, 1'b1);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
           (m_own >= 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 199) == 0), acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
